// File: rtl/booth_radix4_multiplier.sv
// Multi-cycle radix-4 Booth multiplier. X then Y arrive serially on inBus, and the
// 2*WIDTH product leaves on outBus as two halves, high half first.
//
// state  | meaning
// IDLE   | waiting for start; X and mode captured with start
// LOADY  | Y captured, accumulator and recoding bit cleared
// CALC   | one Booth digit (two multiplier bits) retired per cycle
// OUTH   | product high half on outBus
// OUTL   | product low half on outBus
module booth_radix4_multiplier #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] inBus,
  output logic             busy,
  output logic             done,
  output logic             out_hi,
  output logic [WIDTH-1:0] outBus
);

  localparam int EW   = WIDTH + 2;
  localparam int ITER = EW / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADY = 3'd1,
    S_CALC  = 3'd2,
    S_OUTH  = 3'd3,
    S_OUTL  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic            mode_q, mode_d;
  logic [EW:0]     a_q, a_d;
  logic [EW-1:0]   y_q, y_d;
  logic            ym1_q, ym1_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [EW-1:0]       x_ext;
  logic [EW:0]         x_ext1;
  logic [EW:0]         pp;
  logic [EW:0]         sum;
  logic signed [2*EW+1:0] shifted;
  logic [2*WIDTH-1:0]  prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      y_q     <= '0;
      ym1_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      y_q     <= y_d;
      ym1_q   <= ym1_d;
      cnt_q   <= cnt_d;
    end
  end

  // Booth digit selection; A carries one guard bit so +/-2X never overflows
  always_comb begin
    x_ext  = mode_q ? {{2{x_q[WIDTH-1]}}, x_q} : {2'b00, x_q};
    x_ext1 = {x_ext[EW-1], x_ext};
    pp     = '0;
    case ({y_q[1:0], ym1_q})
      3'b001, 3'b010: pp = x_ext1;
      3'b011:         pp = x_ext1 << 1;
      3'b100:         pp = -(x_ext1 << 1);
      3'b101, 3'b110: pp = -x_ext1;
      default:        pp = '0;
    endcase
    sum     = a_q + pp;
    shifted = $signed({sum, y_q, ym1_q}) >>> 2;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    a_d     = a_q;
    y_d     = y_q;
    ym1_d   = ym1_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = inBus;
          mode_d  = is_signed;
          state_d = S_LOADY;
        end
      end
      S_LOADY: begin
        y_d     = mode_q ? {{2{inBus[WIDTH-1]}}, inBus} : {2'b00, inBus};
        a_d     = '0;
        ym1_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        a_d   = shifted[2*EW+1 -: EW+1];
        y_d   = shifted[EW -: EW];
        ym1_d = shifted[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = S_OUTH;
      end
      S_OUTH:  state_d = S_OUTL;
      S_OUTL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // After ITER steps, Y holds the low EW product bits and A the rest
  assign prod = {a_q[WIDTH-3:0], y_q};

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_OUTH) || (state_q == S_OUTL);
    out_hi = (state_q == S_OUTH);
    outBus = '0;
    if (state_q == S_OUTH)      outBus = prod[2*WIDTH-1:WIDTH];
    else if (state_q == S_OUTL) outBus = prod[WIDTH-1:0];
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: WIDTH=6 directed + exhaustive, WIDTH=16 random,
// both checked against plain integer multiplication.
module tb_booth_radix4_multiplier;

  localparam int IT6  = 4;
  localparam int IT16 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst6, start6, sg6, busy6, done6, hi6;
  logic [5:0]  in6, out6;
  logic        rst16, start16, sg16, busy16, done16, hi16;
  logic [15:0] in16, out16;

  int errors = 0;
  int checks = 0;
  logic [11:0] q6[$];
  logic [31:0] q16[$];
  int run6 = 0;
  int run16 = 0;

  booth_radix4_multiplier #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst6), .start(start6), .is_signed(sg6), .inBus(in6),
    .busy(busy6), .done(done6), .out_hi(hi6), .outBus(out6));

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .is_signed(sg16), .inBus(in16),
    .busy(busy16), .done(done16), .out_hi(hi16), .outBus(out16));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input bit s);
    longint one = 1;
    longint mask = (one << w) - 1;
    longint a = longint'(x) & mask;
    longint b = longint'(y) & mask;
    longint p;
    if (s && x[w-1]) a = a - (one << w);
    if (s && y[w-1]) b = b - (one << w);
    p = a * b;
    return 64'(p & ((one << (2 * w)) - 1));
  endfunction

  // Single compare process: every cycle, each DUT's outBus must be 0 or the queued product half
  always @(negedge clk) begin
    if (rst6) begin
      if (!done6) begin
        run6 = 0;
        chk("w6_idle_outbus", 64'(out6), 64'd0);
      end else begin
        run6++;
        chk("w6_done_run_le2", 64'(run6 <= 2), 64'd1);
        if (q6.size() == 0) chk("w6_unexpected_done", 64'd1, 64'd0);
        else if (hi6) chk("w6_hi", 64'(out6), 64'(q6[0][11:6]));
        else begin
          chk("w6_lo", 64'(out6), 64'(q6[0][5:0]));
          void'(q6.pop_front());
        end
      end
    end
    if (rst16) begin
      if (!done16) begin
        run16 = 0;
        chk("w16_idle_outbus", 64'(out16), 64'd0);
      end else begin
        run16++;
        chk("w16_done_run_le2", 64'(run16 <= 2), 64'd1);
        if (q16.size() == 0) chk("w16_unexpected_done", 64'd1, 64'd0);
        else if (hi16) chk("w16_hi", 64'(out16), 64'(q16[0][31:16]));
        else begin
          chk("w16_lo", 64'(out16), 64'(q16[0][15:0]));
          void'(q16.pop_front());
        end
      end
    end
  end

  // Called just after a negedge in an IDLE cycle; returns just after the negedge of the next IDLE cycle
  task automatic op6(input logic [5:0] x, input logic [5:0] y, input bit s,
                     input bit hold, input logic [11:0] exp);
    start6 = 1'b1; sg6 = s; in6 = x;
    q6.push_back(exp);
    @(negedge clk);
    chk("w6_busy_loady", 64'(busy6), 64'd1);
    start6 = hold; sg6 = ~s; in6 = y;
    for (int k = 2; k <= IT6 + 3; k++) begin
      @(negedge clk);
      in6 = 6'($urandom);
      if (k == IT6 + 1) chk("w6_no_early_done", 64'(done6), 64'd0);
      if (k == IT6 + 2) chk("w6_done_hi_cycle", 64'({done6, hi6}), 64'd3);
      if (k == IT6 + 3) chk("w6_done_lo_cycle", 64'({done6, hi6}), 64'd2);
    end
    @(negedge clk);
    chk("w6_idle_after", 64'({busy6, done6}), 64'd0);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input bit s);
    start16 = 1'b1; sg16 = s; in16 = x;
    q16.push_back(32'(ref_mul(16, 32'(x), 32'(y), s)));
    @(negedge clk);
    start16 = 1'b0; in16 = y;
    for (int k = 2; k <= IT16 + 3; k++) begin
      @(negedge clk);
      in16 = 16'($urandom);
      if (k == IT16 + 2) chk("w16_done_hi_cycle", 64'({done16, hi16}), 64'd3);
      if (k == IT16 + 3) chk("w16_done_lo_cycle", 64'({done16, hi16}), 64'd2);
    end
    @(negedge clk);
    chk("w16_idle_after", 64'(busy16), 64'd0);
  endtask

  task automatic seq6();
    logic [5:0] xa, xb;
    rst6 = 1'b0; start6 = 1'b0; sg6 = 1'b0; in6 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy6), 64'd0);
    chk("rst_done", 64'(done6), 64'd0);
    chk("rst_out_hi", 64'(hi6), 64'd0);
    chk("rst_outbus", 64'(out6), 64'd0);
    rst6 = 1'b1;
    @(negedge clk);

    chk("model_m3x5", ref_mul(6, 32'h3D, 32'h05, 1'b1), 64'hFF1);
    chk("model_m32xm32", ref_mul(6, 32'h20, 32'h20, 1'b1), 64'h400);
    chk("model_63x63", ref_mul(6, 32'h3F, 32'h3F, 1'b0), 64'hF81);
    chk("model_7x7", ref_mul(6, 32'h07, 32'h07, 1'b0), 64'h031);
    chk("model_16b_signed", ref_mul(16, 32'h8000, 32'h8000, 1'b1), 64'h4000_0000);

    op6(6'h3D, 6'h05, 1'b1, 1'b0, 12'hFF1);
    op6(6'h20, 6'h20, 1'b1, 1'b0, 12'h400);
    op6(6'h3F, 6'h3F, 1'b0, 1'b0, 12'hF81);

    // start held high through the first op, second op begins at its first IDLE cycle
    op6(6'h05, 6'h09, 1'b0, 1'b1, 12'h02D);
    op6(6'h2A, 6'h13, 1'b1, 1'b0, 12'((-22) * 19));

    // abort in the second CALC cycle
    xa = 6'h11; xb = 6'h22;
    start6 = 1'b1; sg6 = 1'b0; in6 = xa;
    @(negedge clk);
    start6 = 1'b0; in6 = xb;
    repeat (2) @(negedge clk);
    #2 rst6 = 1'b0;
    #1;
    chk("abort_busy", 64'(busy6), 64'd0);
    chk("abort_done", 64'(done6), 64'd0);
    chk("abort_outbus", 64'(out6), 64'd0);
    @(negedge clk);
    rst6 = 1'b1;
    @(negedge clk);
    op6(6'h07, 6'h07, 1'b0, 1'b0, 12'h031);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 64; x++)
        for (int y = 0; y < 64; y++)
          op6(6'(x), 6'(y), s[0], 1'b0, 12'(ref_mul(6, 32'(x), 32'(y), s[0])));
    repeat (2) @(negedge clk);
  endtask

  task automatic seq16();
    rst16 = 1'b0; start16 = 1'b0; sg16 = 1'b0; in16 = '0;
    repeat (2) @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    op16(16'h8000, 16'h8000, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'h0000, 16'hBEEF, 1'b1);
    for (int i = 0; i < 3000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      seq6();
      seq16();
    join
    chk("w6_queue_drained", 64'(q6.size()), 64'd0);
    chk("w16_queue_drained", 64'(q16.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
